// File: rtl/bp_be_issue_ctl.sv
// rtl/bp_be_issue_ctl.sv - backend issue queue sequencer: control strobes, in-flight tracking, dispatch credit
module bp_be_issue_ctl #(
    parameter int compressed_support_p = 1,
    parameter int inflight_max_p       = 8,
    parameter int min_suppress_p       = 2,
    localparam int CNT_W = $clog2(inflight_max_p + 1),
    localparam int SUP_W = (min_suppress_p > 0) ? $clog2(min_suppress_p + 1) : 1
) (
    input  logic             clk_i,
    input  logic             reset_n_i,
    input  logic             issue_v_i,
    input  logic             issue_compressed_i,
    input  logic             dispatch_ready_i,
    input  logic             commit_v_i,
    input  logic             commit_compressed_i,
    input  logic             replay_v_i,
    input  logic             redirect_v_i,
    input  logic             fe_cmd_done_i,
    input  logic             irq_v_i,
    input  logic             inject_done_i,
    output logic             clr_v_o,
    output logic             deq_v_o,
    output logic             deq_skip_o,
    output logic             roll_v_o,
    output logic             inject_v_o,
    output logic             suppress_v_o,
    output logic             read_v_o,
    output logic             read_skip_o,
    output logic [CNT_W-1:0] inflight_cnt_o,
    output logic             busy_o
);

    typedef enum logic [1:0] {
        e_run      = 2'd0,
        e_suppress = 2'd1,
        e_inject   = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] MAX_C  = CNT_W'(inflight_max_p);
    localparam logic [SUP_W-1:0] SUP_C  = SUP_W'(min_suppress_p);
    localparam logic             SKIP_C = (compressed_support_p != 0);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_inflight;
    logic [SUP_W-1:0] r_sup_cnt;
    logic             r_done;

    logic w_clr, w_deq, w_roll, w_inject, w_sup, w_read;
    logic w_cnt_clear, w_sup_load, w_room;

    // A commit in the same cycle frees a slot, so a full window can still read.
    assign w_room = (r_inflight < MAX_C) | commit_v_i;

    always_comb begin
        w_state_nxt = r_state;
        w_clr       = 1'b0;
        w_deq       = 1'b0;
        w_roll      = 1'b0;
        w_inject    = 1'b0;
        w_sup       = 1'b0;
        w_read      = 1'b0;
        w_cnt_clear = 1'b0;
        w_sup_load  = 1'b0;
        case (r_state)
            e_run: begin
                if (redirect_v_i) begin
                    w_clr       = 1'b1;
                    w_sup       = 1'b1;
                    w_cnt_clear = 1'b1;
                    w_sup_load  = 1'b1;
                    w_state_nxt = e_suppress;
                end else if (replay_v_i) begin
                    w_roll      = 1'b1;
                    w_deq       = commit_v_i;
                    w_cnt_clear = 1'b1;
                end else if (irq_v_i) begin
                    w_deq = commit_v_i;
                    if (r_inflight == '0) begin
                        w_inject    = 1'b1;
                        w_state_nxt = e_inject;
                    end
                end else begin
                    w_read = issue_v_i & dispatch_ready_i & w_room;
                    w_deq  = commit_v_i;
                end
            end
            e_suppress: begin
                w_sup = 1'b1;
                if (redirect_v_i) begin
                    w_clr      = 1'b1;
                    w_sup_load = 1'b1;
                end else if ((r_sup_cnt <= SUP_W'(1)) && (r_done | fe_cmd_done_i)) begin
                    // Counter reaches zero on this edge; leave together with it.
                    w_state_nxt = e_run;
                end
            end
            e_inject: begin
                if (redirect_v_i) begin
                    w_clr       = 1'b1;
                    w_sup       = 1'b1;
                    w_cnt_clear = 1'b1;
                    w_sup_load  = 1'b1;
                    w_state_nxt = e_suppress;
                end else begin
                    w_inject = 1'b1;
                    if (inject_done_i) begin
                        w_state_nxt = e_run;
                    end
                end
            end
            default: w_state_nxt = e_run;
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_state    <= e_run;
            r_inflight <= '0;
            r_sup_cnt  <= '0;
            r_done     <= 1'b0;
        end else begin
            r_state <= w_state_nxt;

            if (w_cnt_clear) begin
                r_inflight <= '0;
            end else if (w_read && !w_deq) begin
                r_inflight <= r_inflight + CNT_W'(1);
            end else if (!w_read && w_deq && (r_inflight != '0)) begin
                r_inflight <= r_inflight - CNT_W'(1);
            end

            if (w_sup_load) begin
                r_sup_cnt <= SUP_C;
            end else if ((r_state == e_suppress) && (r_sup_cnt != '0)) begin
                r_sup_cnt <= r_sup_cnt - SUP_W'(1);
            end

            if (w_sup_load) begin
                r_done <= 1'b0;
            end else if (r_state == e_suppress) begin
                r_done <= r_done | fe_cmd_done_i;
            end else begin
                r_done <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_n_i) begin
            assert (!(w_deq && !w_cnt_clear && (r_inflight == '0)))
                else $error("commit with no instruction in flight");
            assert (!(w_clr && w_roll)) else $error("clr with roll");
            assert (!(w_inject && w_read)) else $error("inject with read");
            assert (!(w_sup && w_read)) else $error("read while suppressed");
        end
    end

    assign clr_v_o        = reset_n_i & w_clr;
    assign deq_v_o        = reset_n_i & w_deq;
    assign deq_skip_o     = reset_n_i & SKIP_C & w_deq & ~commit_compressed_i;
    assign roll_v_o       = reset_n_i & w_roll;
    assign inject_v_o     = reset_n_i & w_inject;
    assign suppress_v_o   = reset_n_i & w_sup;
    assign read_v_o       = reset_n_i & w_read;
    assign read_skip_o    = reset_n_i & SKIP_C & w_read & ~issue_compressed_i;
    assign inflight_cnt_o = r_inflight;
    assign busy_o         = reset_n_i & (r_state != e_run);

endmodule
